// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : pipeline stall/flush control with CSR drain and perf counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_ID,
  input  logic [31:0]      inst_Ex,
  input  logic             br_taken_Ex,
  input  logic             mem_stall,
  output logic [2:0]       reg_mux_sel,
  output logic             pc_stall,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              DC_W         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] C_DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);
  localparam logic [2:0]      C_SEL_NORMAL = 3'b001;
  localparam logic [2:0]      C_SEL_BUBBLE = 3'b010;
  localparam logic [2:0]      C_SEL_HOLD   = 3'b100;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [6:0] op_id;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       uses_rs1, uses_rs2, load_ex, csr_id, load_use;
  logic       unused_bits;

  assign op_id  = inst_ID[6:0];
  assign rs1_id = inst_ID[19:15];
  assign rs2_id = inst_ID[24:20];
  assign rd_ex  = inst_Ex[11:7];

  // LUI, AUIPC and JAL carry immediate bits where rs1 would sit
  assign uses_rs1 = !((op_id == 7'b0110111) || (op_id == 7'b0010111) ||
                      (op_id == 7'b1101111));
  assign uses_rs2 = (op_id == 7'b0110011) || (op_id == 7'b0100011) ||
                    (op_id == 7'b1100011);
  assign load_ex  = (inst_Ex[6:0] == 7'b0000011) && (rd_ex != 5'd0);
  assign csr_id   = (op_id == 7'b1110011) && (inst_ID[14:12] != 3'b000);
  assign load_use = load_ex && ((uses_rs1 && (rs1_id == rd_ex)) ||
                                (uses_rs2 && (rs2_id == rd_ex)));

  assign unused_bits = ^{inst_ID[31:25], inst_ID[11:7], inst_Ex[31:12]};

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    reg_mux_sel = C_SEL_NORMAL;
    pc_stall    = 1'b0;
    if_flush    = 1'b0;
    if (!reset) begin
      reg_mux_sel = C_SEL_BUBBLE;
      pc_stall    = 1'b1;
      if_flush    = 1'b1;
    end else if (mem_stall) begin
      reg_mux_sel = C_SEL_HOLD;
      pc_stall    = 1'b1;
    end else if (br_taken_Ex) begin
      reg_mux_sel = C_SEL_BUBBLE;
      if_flush    = 1'b1;
      state_d     = ST_RUN;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        ST_DRAIN: begin
          reg_mux_sel = C_SEL_BUBBLE;
          pc_stall    = 1'b1;
          drain_cnt_d = drain_cnt_q - DC_W'(1);
          if (drain_cnt_q <= DC_W'(1)) begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          if (csr_id) begin
            reg_mux_sel = C_SEL_BUBBLE;
            pc_stall    = 1'b1;
            if (DRAIN_CYCLES == 1) begin
              state_d     = ST_ISSUE;
              drain_cnt_d = '0;
            end else begin
              state_d     = ST_DRAIN;
              drain_cnt_d = C_DRAIN_LOAD;
            end
          end else if (load_use) begin
            // one bubble suffices: next cycle the load has left EX
            reg_mux_sel = C_SEL_BUBBLE;
            pc_stall    = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : table-driven scoreboard bench for hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  localparam logic [31:0] C_NOP    = 32'h0000_0013;
  localparam logic [31:0] C_LW5    = 32'h0000_A283;
  localparam logic [31:0] C_LW1    = 32'h0000_A083;
  localparam logic [31:0] C_ADDUSE = 32'h0022_8333;
  localparam logic [31:0] C_LB0    = 32'h0000_8003;
  localparam logic [31:0] C_ADD000 = 32'h0000_0033;
  localparam logic [31:0] C_JAL    = 32'h0050_00EF;
  localparam logic [31:0] C_SW     = 32'h0051_2023;
  localparam logic [31:0] C_ADDI   = 32'h0050_0313;
  localparam logic [31:0] C_LUI    = 32'h0002_8337;
  localparam logic [31:0] C_ADD5   = 32'h0020_82B3;
  localparam logic [31:0] C_BEQ    = 32'h0050_0063;
  localparam logic [31:0] C_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_CSR    = 32'h3000_9073;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ex;
    logic        br;
    logic        ms;
    logic [2:0]  sel;
    logic        stall;
    logic        flush;
    string       name;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic       stall;
    logic       flush;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_ID, inst_Ex;
  logic        br_taken_Ex, mem_stall;
  logic [2:0]  reg_mux_sel;
  logic        pc_stall, if_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic        reset2;
  logic [31:0] inst_ID2;
  logic [31:0] inst_Ex2 = 32'h0;
  logic        br2 = 1'b0;
  logic        ms2;
  logic [2:0]  reg_mux_sel2;
  logic        pc_stall2, if_flush2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  int   checks = 0;
  int   errors = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  exp_t sb[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .inst_ID(inst_ID), .inst_Ex(inst_Ex),
    .br_taken_Ex(br_taken_Ex), .mem_stall(mem_stall),
    .reg_mux_sel(reg_mux_sel), .pc_stall(pc_stall), .if_flush(if_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .inst_ID(inst_ID2), .inst_Ex(inst_Ex2),
    .br_taken_Ex(br2), .mem_stall(ms2),
    .reg_mux_sel(reg_mux_sel2), .pc_stall(pc_stall2), .if_flush(if_flush2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of stimulus, compare on the falling edge, then advance
  task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic br,
                      input logic ms, input logic [2:0] sel, input logic stall,
                      input logic flush, input string name);
    exp_t e;
    inst_ID = id; inst_Ex = ex; br_taken_Ex = br; mem_stall = ms;
    sb.push_back('{sel, stall, flush, name});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".sel"},   32'(reg_mux_sel), 32'(e.sel));
    check({e.name, ".stall"}, 32'(pc_stall),    32'(e.stall));
    check({e.name, ".flush"}, 32'(if_flush),    32'(e.flush));
    check({e.name, ".scnt"},  32'(stall_cnt),   32'(m_stall));
    check({e.name, ".fcnt"},  32'(flush_cnt),   32'(m_flush));
    @(posedge clk); #1;
    if (e.stall) m_stall++;
    if (e.flush) m_flush++;
  endtask

  always @(negedge clk) begin
    checks++;
    if (!$onehot(reg_mux_sel) || !$onehot(reg_mux_sel2)) begin
      errors++;
      $display("FAIL onehot: got %b / %b, expected one-hot", reg_mux_sel, reg_mux_sel2);
    end
  end

  initial begin
    int base;
    vecs[0]  = '{C_NOP,    C_NOP,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "idle"};
    vecs[1]  = '{C_ADDUSE, C_LW5,   1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "lu_rs1"};
    vecs[2]  = '{C_ADDUSE, 32'h0,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "lu_bubble"};
    vecs[3]  = '{C_ADD000, C_LB0,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "lb_x0"};
    vecs[4]  = '{C_JAL,    C_LW5,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "jal_rs2"};
    vecs[5]  = '{C_SW,     C_LW5,   1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "lu_sw_rs2"};
    vecs[6]  = '{C_ADDI,   C_LW5,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "addi_rs2"};
    vecs[7]  = '{C_LUI,    C_LW5,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "lui_rs1"};
    vecs[8]  = '{C_ADDUSE, C_ADD5,  1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "not_load"};
    vecs[9]  = '{C_BEQ,    C_LW5,   1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "lu_beq"};
    vecs[10] = '{C_ADDUSE, C_LW5,   1'b1, 1'b0, 3'b010, 1'b0, 1'b1, "br_over_lu"};
    vecs[11] = '{C_ECALL,  C_NOP,   1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "ecall"};
    vecs[12] = '{C_NOP,    C_NOP,   1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "memstall"};
    vecs[13] = '{C_NOP,    C_NOP,   1'b1, 1'b1, 3'b100, 1'b1, 1'b0, "ms_over_br"};
    vecs[14] = '{C_NOP,    C_NOP,   1'b1, 1'b0, 3'b010, 1'b0, 1'b1, "branch"};

    reset = 1'b0; reset2 = 1'b0;
    inst_ID = C_NOP; inst_Ex = C_NOP; br_taken_Ex = 1'b0; mem_stall = 1'b0;
    inst_ID2 = C_NOP; ms2 = 1'b0;
    #3;
    check("rst.sel",   32'(reg_mux_sel), 32'h2);
    check("rst.stall", 32'(pc_stall),    32'h1);
    check("rst.flush", 32'(if_flush),    32'h1);
    check("rst.scnt",  32'(stall_cnt),   32'h0);
    check("rst.fcnt",  32'(flush_cnt),   32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; reset2 = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].id, vecs[i].ex, vecs[i].br, vecs[i].ms,
           vecs[i].sel, vecs[i].stall, vecs[i].flush, vecs[i].name);
    end

    // CSR drain with a load-use present during ISSUE
    base = m_stall;
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "csr_run");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "csr_drain1");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "csr_drain2");
    step(C_CSR, C_LW1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "csr_issue");
    step(C_NOP, C_NOP, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "csr_after");
    check("csr_total_stall", 32'(stall_cnt) - 32'(base), 32'd3);

    // branch aborts a drain
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "br_csr_run");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "br_drain1");
    step(C_CSR, C_NOP, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, "br_drain2");
    step(C_NOP, C_NOP, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "br_after");

    // memory stall freezes a drain, then the drain resumes
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "ms_csr_run");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "ms_drain1");
    step(C_CSR, C_NOP, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "ms_hold1");
    step(C_CSR, C_NOP, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, "ms_hold2_br");
    step(C_CSR, C_NOP, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "ms_hold3");
    step(C_CSR, C_NOP, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, "ms_hold4");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "ms_resume");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "ms_issue");
    step(C_NOP, C_NOP, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "ms_after");

    // asynchronous reset between edges while draining
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "ar_csr_run");
    step(C_CSR, C_NOP, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, "ar_drain1");
    #2 reset = 1'b0;
    #1;
    check("ar.sel",   32'(reg_mux_sel), 32'h2);
    check("ar.stall", 32'(pc_stall),    32'h1);
    check("ar.flush", 32'(if_flush),    32'h1);
    check("ar.scnt",  32'(stall_cnt),   32'h0);
    check("ar.fcnt",  32'(flush_cnt),   32'h0);
    m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    check("ar_held.scnt", 32'(stall_cnt), 32'h0);
    reset = 1'b1;
    step(C_NOP, C_NOP, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, "ar_after");

    // DRAIN_CYCLES=1 goes straight to ISSUE; CNT_W=4 saturates
    inst_ID2 = C_CSR;
    @(negedge clk);
    check("d1_run.sel",   32'(reg_mux_sel2), 32'h2);
    check("d1_run.stall", 32'(pc_stall2),    32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("d1_issue.sel",   32'(reg_mux_sel2), 32'h1);
    check("d1_issue.stall", 32'(pc_stall2),    32'h0);
    @(posedge clk); #1;
    check("d1.scnt", 32'(stall_cnt2), 32'h1);
    inst_ID2 = C_NOP; ms2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sat.sel", 32'(reg_mux_sel2), 32'h4);
      @(posedge clk); #1;
    end
    ms2 = 1'b0;
    @(negedge clk);
    check("sat.scnt", 32'(stall_cnt2), 32'd15);
    check("sat.fcnt", 32'(flush_cnt2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, the number of bubble cycles inserted before a CSR instruction leaves ID.
REQ-002 SHALL have parameter CNT_W, default 16, the width of each performance counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 inst_ID  in  32  instruction in ID.
REQ-006 inst_Ex  in  32  instruction in EX.
REQ-007 br_taken_Ex  in  1  branch taken or jump resolved in EX this cycle.
REQ-008 mem_stall  in  1  data memory not ready; freeze the whole pipeline.
REQ-009 reg_mux_sel  out  3  ID/EX register select, one-hot: 001 normal, 010 flush/bubble, 100 hold.
REQ-010 pc_stall  out  1  hold PC and the IF/ID register.
REQ-011 if_flush  out  1  zero the IF/ID register.
REQ-012 stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating.
REQ-013 flush_cnt  out  CNT_W  cycles with if_flush=1, saturating.

Function
REQ-014 SHALL implement an FSM with states RUN, DRAIN and ISSUE, plus a down-counter drain_cnt of width clog2(DRAIN_CYCLES+1).
REQ-015 Decode SHALL be as follows:
- load_Ex: inst_Ex[6:0]=0000011 and inst_Ex[11:7]!=0.
- ID uses rs1 for every opcode except 0110111, 0010111 and 1101111.
- ID uses rs2 for opcodes 0110011, 0100011 and 1100011.
- csr_ID: inst_ID[6:0]=1110011 and inst_ID[14:12]!=000.
REQ-016 load_use SHALL be load_Ex and (inst_Ex[11:7] matches a used rs1 inst_ID[19:15] or a used rs2 inst_ID[24:20]).
REQ-017 Outputs SHALL be combinational from state and inputs, evaluated in strict priority; the first matching row wins:
- mem_stall=1: reg_mux_sel=100, pc_stall=1, if_flush=0, and the FSM and drain_cnt hold.
- br_taken_Ex=1: reg_mux_sel=010, pc_stall=0, if_flush=1, and the next state is RUN, aborting any DRAIN or ISSUE.
- state DRAIN: reg_mux_sel=010, pc_stall=1, if_flush=0, and drain_cnt decrements; when drain_cnt=1, the next state is ISSUE.
- state ISSUE: reg_mux_sel=001, pc_stall=0, if_flush=0, and the next state is RUN.
- RUN with csr_ID: reg_mux_sel=010, pc_stall=1, and the next state is DRAIN with drain_cnt=DRAIN_CYCLES-1; if DRAIN_CYCLES=1, the next state is ISSUE directly.
- RUN with load_use: reg_mux_sel=010, pc_stall=1, if_flush=0, for exactly one cycle, because the bubble then occupies EX.
- Otherwise: reg_mux_sel=001, pc_stall=0, if_flush=0.
REQ-018 In ISSUE, the CSR SHALL pass without re-triggering the drain, and load_use is not evaluated in ISSUE.
REQ-019 reg_mux_sel SHALL always be exactly one-hot; 000 and multi-hot values never occur.
REQ-020 Each counter SHALL increment by 1 on a rising edge when its condition is true, and hold at 2^CNT_W-1 once reached.
REQ-021 The total ID stall for a CSR with no interference SHALL be DRAIN_CYCLES cycles, and the CSR enters EX on the edge ending ISSUE.

Reset
REQ-022 While reset=0, the block SHALL hold state=RUN, drain_cnt=0, stall_cnt=0 and flush_cnt=0, with outputs reg_mux_sel=010, pc_stall=1 and if_flush=1, independent of clk.
REQ-023 Reset assertion mid-DRAIN SHALL abandon the drain immediately.
REQ-024 After reset deasserts, the first rising edge SHALL evaluate from RUN.

Verification
REQ-025 Load-use: inst_Ex=0x0000A283 (lw x5), inst_ID=0x00228333 (add x6,x5,x2). Required response: one cycle of reg_mux_sel=010 and pc_stall=1, then 001 once inst_Ex becomes a bubble (0x00000000); stall_cnt=1.
REQ-026 No load-use on x0 or unused rs2: inst_Ex=0x00008003 (lb x0), or inst_Ex rd=5 with inst_ID=0x005000EF (jal). Required response: reg_mux_sel stays 001 and pc_stall stays 0.
REQ-027 CSR drain: inst_ID=0x30009073 held, DRAIN_CYCLES=3. Required response: reg_mux_sel=010 and pc_stall=1 for 3 cycles, then ISSUE with 001 for 1 cycle, then RUN; stall_cnt=3.
REQ-028 Branch during drain: br_taken_Ex=1 on the 2nd DRAIN cycle. Required response: that cycle if_flush=1, reg_mux_sel=010, pc_stall=0; the next state is RUN; flush_cnt=1.
REQ-029 mem_stall priority: mem_stall=1 for 4 cycles during DRAIN, with br_taken_Ex=1 on one of them. Required response: reg_mux_sel=100 and if_flush=0 throughout; drain_cnt is unchanged and the drain resumes afterwards.
REQ-030 Async reset and saturation: reset=0 mid-DRAIN, between clock edges. Required response: outputs go to 010/1/1 at once. Then, with CNT_W=4 and 20 consecutive stall cycles, stall_cnt=15.
